// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready   operand pair handshake (fp_X, fp_Y, r_mode)
//   out_valid/out_ready result handshake (fp_Z, ovrf, udrf)
// slave is the multiplier's view, master the producer/consumer's view.
interface fp_mul_if #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
);
  localparam int W = 1 + EXP_W + FRC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] fp_X;
  logic [W-1:0] fp_Y;
  logic [2:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fp_Z;
  logic         ovrf;
  logic         udrf;

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf
  );

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier, fp_Z = fp_X * fp_Y.
// Flush-to-zero for subnormal inputs (flushed to +0), no subnormal outputs,
// five rounding modes, overflow/underflow flags valid with out_valid.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_mul_if.slave: in_valid/in_ready/fp_X/fp_Y/r_mode in,
//          out_valid/out_ready/fp_Z/ovrf/udrf out
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input logic     clk,
  input logic     rst_n,
  fp_mul_if.slave bus
);
  localparam int W    = 1 + EXP_W + FRC_W;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = FRC_W + 1;
  localparam int PW   = 2 * FRC_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_t;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: unpack / classify / sign / exponent sum
  logic             xs, ys;
  logic [EXP_W-1:0] xe, ye;
  logic [FRC_W-1:0] xf, yf;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic             sx_eff, sy_eff, sgn_c, nan_c;
  logic             spec_n;
  logic [W-1:0]     spec_val_n;
  logic signed [EW-1:0] e_c;
  rnd_t             rm_c;

  assign xs = bus.fp_X[W-1];
  assign ys = bus.fp_Y[W-1];
  assign xe = bus.fp_X[W-2 -: EXP_W];
  assign ye = bus.fp_Y[W-2 -: EXP_W];
  assign xf = bus.fp_X[FRC_W-1:0];
  assign yf = bus.fp_Y[FRC_W-1:0];

  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (xe == '1) && (xf == '0);
  assign y_inf  = (ye == '1) && (yf == '0);
  assign x_nan  = (xe == '1) && (xf != '0);
  assign y_nan  = (ye == '1) && (yf != '0);

  // Subnormals flush to +0; only a true zero keeps its sign.
  assign sx_eff = xs && !(x_zero && (xf != '0));
  assign sy_eff = ys && !(y_zero && (yf != '0));
  assign sgn_c  = sx_eff ^ sy_eff;
  assign nan_c  = x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero);

  assign e_c = $signed({2'b00, xe}) + $signed({2'b00, ye}) - BIAS_S;

  always_comb begin
    spec_n     = 1'b1;
    spec_val_n = '0;
    if (nan_c)
      spec_val_n = QNAN;
    else if (x_inf || y_inf)
      spec_val_n = {sgn_c, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
    else if (x_zero || y_zero)
      spec_val_n = {sgn_c, {(W-1){1'b0}}};
    else
      spec_n = 1'b0;
  end

  always_comb begin
    case (bus.r_mode)
      3'd1:    rm_c = RTZ;
      3'd2:    rm_c = RDN;
      3'd3:    rm_c = RUP;
      3'd4:    rm_c = RMM;
      default: rm_c = RNE;
    endcase
  end

  logic                 s1_v, s1_sign, s1_spec;
  logic [W-1:0]         s1_spec_val;
  logic signed [EW-1:0] s1_e;
  logic [MW-1:0]        s1_mx, s1_my;
  rnd_t                 s1_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v        <= 1'b0;
      s1_sign     <= 1'b0;
      s1_spec     <= 1'b0;
      s1_spec_val <= '0;
      s1_e        <= '0;
      s1_mx       <= '0;
      s1_my       <= '0;
      s1_rm       <= RNE;
    end else if (adv) begin
      s1_v        <= bus.in_valid;
      s1_sign     <= sgn_c;
      s1_spec     <= spec_n;
      s1_spec_val <= spec_val_n;
      s1_e        <= e_c;
      s1_mx       <= {1'b1, xf};
      s1_my       <= {1'b1, yf};
      s1_rm       <= rm_c;
    end
  end

  // ---------------- S2: mantissa product
  logic                 s2_v, s2_sign, s2_spec;
  logic [W-1:0]         s2_spec_val;
  logic signed [EW-1:0] s2_e;
  logic [PW-1:0]        s2_p;
  rnd_t                 s2_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_val <= '0;
      s2_e        <= '0;
      s2_p        <= '0;
      s2_rm       <= RNE;
    end else if (adv) begin
      s2_v        <= s1_v;
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_e        <= s1_e;
      s2_p        <= PW'(s1_mx) * PW'(s1_my);
      s2_rm       <= s1_rm;
    end
  end

  // ---------------- S3: normalise / round / pack / flags
  // pn holds the product with its leading one dropped, so the fraction,
  // guard and sticky fields sit at fixed positions in either case.
  logic [PW-2:0]        pn;
  logic signed [EW-1:0] en, er;
  logic [FRC_W-1:0]     frac, fr;
  logic                 g, st, inc, to_inf;
  logic [FRC_W:0]       rsum;
  logic [W-1:0]         z_n;
  logic                 of_n, uf_n;

  always_comb begin
    pn     = s2_p[PW-1] ? s2_p[PW-2:0] : {s2_p[PW-3:0], 1'b0};
    en     = s2_e + $signed({{(EW-1){1'b0}}, s2_p[PW-1]});
    frac   = pn[PW-2 -: FRC_W];
    g      = pn[PW-2-FRC_W];
    st     = |pn[PW-3-FRC_W:0];
    case (s2_rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = s2_sign && (g || st);
      RUP:     inc = !s2_sign && (g || st);
      RMM:     inc = g;
      default: inc = g && (st || frac[0]);
    endcase
    rsum   = {1'b0, frac} + {{FRC_W{1'b0}}, inc};
    // Carry out of the rounded mantissa means 1.11..1 rounded to 10.00..0.
    er     = en + $signed({{(EW-1){1'b0}}, rsum[FRC_W]});
    fr     = rsum[FRC_W] ? '0 : rsum[FRC_W-1:0];
    to_inf = (s2_rm == RNE) || (s2_rm == RMM) ||
             ((s2_rm == RUP) && !s2_sign) || ((s2_rm == RDN) && s2_sign);
    z_n    = s2_spec_val;
    of_n   = 1'b0;
    uf_n   = 1'b0;
    if (!s2_spec) begin
      if (en <= 0) begin
        z_n  = {s2_sign, {(W-1){1'b0}}};
        uf_n = 1'b1;
      end else if (er >= EMAX_S) begin
        of_n = 1'b1;
        z_n  = to_inf ? {s2_sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}}
                      : {s2_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {FRC_W{1'b1}}};
      end else begin
        z_n  = {s2_sign, er[EXP_W-1:0], fr};
      end
    end
  end

  logic         ov_q, of_q, uf_q;
  logic [W-1:0] z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      z_q  <= '0;
      of_q <= 1'b0;
      uf_q <= 1'b0;
    end else if (adv) begin
      ov_q <= s2_v;
      z_q  <= z_n;
      of_q <= of_n;
      uf_q <= uf_n;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.fp_Z      = z_q;
  assign bus.ovrf      = of_q;
  assign bus.udrf      = uf_q;
endmodule
